// File: rtl/joy_serial_responder.sv
// joy_serial_responder
// Device side of the two-pad serial joystick link. Emulates a 74HC165-style
// parallel-in/serial-out adapter: the host drives joy_clk and joy_load_n
// (both asynchronous, oversampled here) and reads active-low buttons on
// joy_data, pad 1 start first.
// Optional feature macro: JOY_SER_TURBO_EN adds the turbo_mask port and the
// TURBO_DIV autofire divider; the default build has neither.
module joy_serial_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int FRAME_BITS   = 16,
    parameter int IDLE_TIMEOUT = 1048576
`ifdef JOY_SER_TURBO_EN
    ,
    parameter int TURBO_DIV    = 262144
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] joy1_i,
    input  logic [7:0] joy2_i,
`ifdef JOY_SER_TURBO_EN
    input  logic [3:0] turbo_mask,
`endif
    input  logic       joy_clk,
    input  logic       joy_load_n,
    output logic       joy_data,
    output logic       frame_done,
    output logic [4:0] shift_count,
    output logic       link_active
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [4:0] FRAME_COUNT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [SYNC_STAGES-1:0] loadSync_q;
    logic                   clkPrev_q;
    logic                   clkRise;
    logic                   loadSynced;

    logic [7:0]             joy1Eff;
    logic [7:0]             joy2Eff;
    logic [FRAME_BITS-1:0]  frame_q;

    logic [FRAME_BITS-1:0]  shiftReg_q, shiftReg_d;
    logic [4:0]             shiftCount_q, shiftCount_d;
    logic [IDLE_W-1:0]      idleCount_q, idleCount_d;
    logic                   link_q, link_d;
    logic                   frameDone_q, frameDone_d;
    logic                   joyData_q;

    // Synchronizers preset to the idle pin levels so reset release creates no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= '0;
            loadSync_q <= '1;
            clkPrev_q  <= 1'b0;
        end else begin
            clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], joy_clk};
            loadSync_q <= {loadSync_q[SYNC_STAGES-2:0], joy_load_n};
            clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
        end
    end

    assign clkRise    = clkSync_q[SYNC_STAGES-1] & ~clkPrev_q;
    assign loadSynced = loadSync_q[SYNC_STAGES-1];

`ifdef JOY_SER_TURBO_EN
    localparam int TURBO_W = $clog2(TURBO_DIV + 1);
    localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_DIV - 1);

    logic [TURBO_W-1:0] turboCount_q;
    logic               turboPhase_q;

    // Free-running divider flipping the autofire phase every TURBO_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            turboCount_q <= '0;
            turboPhase_q <= 1'b0;
        end else if (turboCount_q == TURBO_LAST) begin
            turboCount_q <= '0;
            turboPhase_q <= ~turboPhase_q;
        end else begin
            turboCount_q <= turboCount_q + 1'b1;
        end
    end

    // Masked A/B buttons only count as pressed during the active turbo phase
    always_comb begin
        joy1Eff = joy1_i;
        joy2Eff = joy2_i;
        if (!turboPhase_q) begin
            joy1Eff[4] = joy1_i[4] & ~turbo_mask[0];
            joy1Eff[6] = joy1_i[6] & ~turbo_mask[1];
            joy2Eff[4] = joy2_i[4] & ~turbo_mask[2];
            joy2Eff[6] = joy2_i[6] & ~turbo_mask[3];
        end
    end
`else
    assign joy1Eff = joy1_i;
    assign joy2Eff = joy2_i;
`endif

    // Active-low snapshot of both pads, pad 1 start in the MSB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q <= '1;
        end else begin
            frame_q <= {~joy1Eff, ~joy2Eff};
        end
    end

    // Load is transparent and beats shifting; idle timeout forces released bits
    always_comb begin
        shiftReg_d   = shiftReg_q;
        shiftCount_d = shiftCount_q;
        idleCount_d  = idleCount_q;
        link_d       = link_q;
        frameDone_d  = 1'b0;
        if (!loadSynced) begin
            shiftReg_d   = frame_q;
            shiftCount_d = '0;
            idleCount_d  = '0;
            link_d       = 1'b1;
        end else begin
            if (idleCount_q < IDLE_MAX) begin
                idleCount_d = idleCount_q + 1'b1;
            end
            if (idleCount_d == IDLE_MAX) begin
                link_d = 1'b0;
            end
            if (clkRise) begin
                shiftReg_d = {shiftReg_q[FRAME_BITS-2:0], 1'b1};
                if (shiftCount_q < FRAME_COUNT) begin
                    shiftCount_d = shiftCount_q + 5'd1;
                    if (shiftCount_q == FRAME_COUNT - 5'd1) begin
                        frameDone_d = 1'b1;
                    end
                end
            end
            if (!link_d) begin
                shiftReg_d = '1;
            end
        end
    end

    // Link state registers plus the registered serial output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shiftReg_q   <= '1;
            shiftCount_q <= '0;
            idleCount_q  <= '0;
            link_q       <= 1'b0;
            frameDone_q  <= 1'b0;
            joyData_q    <= 1'b1;
        end else begin
            shiftReg_q   <= shiftReg_d;
            shiftCount_q <= shiftCount_d;
            idleCount_q  <= idleCount_d;
            link_q       <= link_d;
            frameDone_q  <= frameDone_d;
            joyData_q    <= shiftReg_q[FRAME_BITS-1];
        end
    end

    assign joy_data    = joyData_q;
    assign frame_done  = frameDone_q;
    assign shift_count = shiftCount_q;
    assign link_active = link_q;

endmodule

// File: tb/tb_joy_serial_responder.sv
// tb_joy_serial_responder
// Directed bench for joy_serial_responder: plays the host side of the link
// (load pulse, slow joy_clk) and compares the returned bit stream against
// hand-computed frames. A second instance with a short idle timeout covers
// the link-drop behaviour.
module tb_joy_serial_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       joyClk;
    logic       joyLoadN;

    logic       joyData, frameDone, linkActive;
    logic [4:0] shiftCount;
    logic       joyDataT, frameDoneT, linkT;
    logic [4:0] shiftCountT;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;

    typedef struct {
        logic [7:0]  j1;
        logic [7:0]  j2;
        logic [15:0] bits;
    } vec_t;

    vec_t vecs[4];

    joy_serial_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy1_i     (joy1),
        .joy2_i     (joy2),
`ifdef JOY_SER_TURBO_EN
        .turbo_mask (4'b0000),
`endif
        .joy_clk    (joyClk),
        .joy_load_n (joyLoadN),
        .joy_data   (joyData),
        .frame_done (frameDone),
        .shift_count(shiftCount),
        .link_active(linkActive)
    );

    joy_serial_responder #(.IDLE_TIMEOUT(64)) dutT (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy1_i     (joy1),
        .joy2_i     (joy2),
`ifdef JOY_SER_TURBO_EN
        .turbo_mask (4'b0000),
`endif
        .joy_clk    (joyClk),
        .joy_load_n (joyLoadN),
        .joy_data   (joyDataT),
        .frame_done (frameDoneT),
        .shift_count(shiftCountT),
        .link_active(linkT)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses of the main instance
    always @(negedge clk) begin
        if (frameDone === 1'b1) doneCount++;
    end

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic loadPulse();
        joyLoadN = 1'b0;
        waitClks(8);
        joyLoadN = 1'b1;
        waitClks(8);
    endtask

    task automatic shiftOne();
        joyClk = 1'b1;
        waitClks(8);
        joyClk = 1'b0;
        waitClks(8);
    endtask

    // Load, then sample one bit before each of n shifts (MSB = first bit out)
    task automatic applyStimulus(input int n, output logic [31:0] seq);
        seq = '0;
        loadPulse();
        for (int i = 0; i < n; i++) begin
            seq = {seq[30:0], joyData};
            shiftOne();
        end
    endtask

    initial begin
        logic [31:0] seq;
        int d0;

        vecs[0] = '{j1: 8'h81, j2: 8'h10, bits: 16'h7EEF};
        vecs[1] = '{j1: 8'h00, j2: 8'h00, bits: 16'hFFFF};
        vecs[2] = '{j1: 8'hFF, j2: 8'hFF, bits: 16'h0000};
        vecs[3] = '{j1: 8'h3C, j2: 8'hA5, bits: 16'hC35A};

        reset_n  = 1'b0;
        joy1     = 8'h00;
        joy2     = 8'h00;
        joyClk   = 1'b1;
        joyLoadN = 1'b0;
        waitClks(6);
        checkOutput("reset joy_data", {31'd0, joyData}, 32'd1);
        checkOutput("reset shift_count", {27'd0, shiftCount}, 32'd0);
        checkOutput("reset link_active", {31'd0, linkActive}, 32'd0);
        joyClk   = 1'b0;
        joyLoadN = 1'b1;
        waitClks(2);
        reset_n = 1'b1;
        waitClks(6);
        checkOutput("post-reset link_active", {31'd0, linkActive}, 32'd0);
        checkOutput("post-reset joy_data", {31'd0, joyData}, 32'd1);
        checkOutput("reset frame_done", doneCount, 32'd0);

        for (int v = 0; v < 4; v++) begin
            joy1 = vecs[v].j1;
            joy2 = vecs[v].j2;
            d0 = doneCount;
            applyStimulus(16, seq);
            checkOutput($sformatf("frame %0d bits", v), {16'd0, seq[15:0]}, {16'd0, vecs[v].bits});
            checkOutput($sformatf("frame %0d shift_count", v), {27'd0, shiftCount}, 32'd16);
            checkOutput($sformatf("frame %0d frame_done", v), doneCount - d0, 32'd1);
            checkOutput($sformatf("frame %0d after-last", v), {31'd0, joyData}, 32'd1);
            checkOutput($sformatf("frame %0d link_active", v), {31'd0, linkActive}, 32'd1);
        end

        joy1 = 8'h81;
        joy2 = 8'h10;
        d0 = doneCount;
        applyStimulus(20, seq);
        checkOutput("overshift bits", {12'd0, seq[19:0]}, 32'h7EEFF);
        checkOutput("overshift shift_count", {27'd0, shiftCount}, 32'd16);
        checkOutput("overshift frame_done", doneCount - d0, 32'd1);

        joyLoadN = 1'b0;
        waitClks(8);
        shiftOne();
        checkOutput("rise under load count", {27'd0, shiftCount}, 32'd0);
        checkOutput("rise under load data", {31'd0, joyData}, 32'd0);
        joyLoadN = 1'b1;
        waitClks(8);

        joy1 = 8'h01;
        d0 = doneCount;
        loadPulse();
        checkOutput("reload data", {31'd0, joyData}, 32'd1);
        checkOutput("reload frame_done", doneCount - d0, 32'd0);

        joy1 = 8'hFF;
        joy2 = 8'h00;
        loadPulse();
        seq = '0;
        for (int i = 1; i <= 16; i++) begin
            seq = {seq[30:0], joyData};
            shiftOne();
            if (i == 3) joy1 = 8'h00;
        end
        checkOutput("midframe change", {16'd0, seq[15:0]}, 32'h00FF);

        joy1 = 8'hFF;
        joy2 = 8'hFF;
        loadPulse();
        checkOutput("timeout link up", {31'd0, linkT}, 32'd1);
        checkOutput("timeout data loaded", {31'd0, joyDataT}, 32'd0);
        waitClks(30);
        checkOutput("timeout not yet", {31'd0, linkT}, 32'd1);
        waitClks(60);
        checkOutput("timeout link down", {31'd0, linkT}, 32'd0);
        checkOutput("timeout data", {31'd0, joyDataT}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            shiftOne();
            checkOutput($sformatf("timeout shift %0d", i), {31'd0, joyDataT}, 32'd1);
        end
        loadPulse();
        checkOutput("timeout relink", {31'd0, linkT}, 32'd1);
        checkOutput("timeout reload data", {31'd0, joyDataT}, 32'd0);

        loadPulse();
        shiftOne();
        shiftOne();
        shiftOne();
        reset_n = 1'b0;
        #1;
        checkOutput("midframe reset count", {27'd0, shiftCount}, 32'd0);
        checkOutput("midframe reset data", {31'd0, joyData}, 32'd1);
        checkOutput("midframe reset link", {31'd0, linkActive}, 32'd0);
        waitClks(3);
        reset_n = 1'b1;
        waitClks(4);
        shiftOne();
        checkOutput("no load after reset", {31'd0, joyData}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
